// File: rtl/if_fetch_buffer_if.sv
// Instruction memory bus between the fetch buffer (master) and memory (slave).
// Handshake: the master raises req together with addr and holds both stable
// until the cycle in which the slave drives ack=1. data is valid in that same
// cycle. At most one request is outstanding. ack is only meaningful while req
// is high.
interface if_fetch_buffer_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] data;

   modport master (output req, output addr, input ack, input data);
   modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/if_fetch_buffer.sv
// Instruction prefetch buffer. It issues word fetches from a running fetch PC
// and queues {pc, instr} pairs for the IF/ID stage. A redirect flushes the
// queue and restarts fetching at a new target. A request that is in flight
// when a redirect arrives is allowed to finish, and its data is then dropped.
module if_fetch_buffer #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic                    stall_i,
   input  logic                    redirect_i,
   input  logic [31:0]             redirect_pc_i,
   if_fetch_buffer_if.master       imem,
   output logic                    valid_o,
   output logic [31:0]             pc_o,
   output logic [31:0]             instr_o,
   output logic [1:0]              o_dbg_state,
   output logic [$clog2(DEPTH):0]  o_dbg_count
);
   localparam int unsigned   PW       = $clog2(DEPTH);
   localparam int unsigned   CW       = PW + 1;
   localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_DISCARD = 2'd2
   } state_t;

   state_t        r_state;
   logic [31:0]   r_fpc;
   logic          r_req;
   logic [31:0]   r_addr;
   logic [CW-1:0] r_count;
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [31:0]   r_fifo_pc    [DEPTH];
   logic [31:0]   r_fifo_instr [DEPTH];

   logic          w_valid;
   logic          w_ack;
   logic          w_push;
   logic          w_pop;
   logic          w_can_issue;
   logic [CW-1:0] w_count_next;
   logic [31:0]   w_redirect_pc;
   logic [31:0]   w_fpc_next;

   assign w_valid       = (r_count != '0);
   assign w_ack         = r_req & imem.ack;
   // Data acked in DISCARD, or acked in the same cycle as a redirect, is stale.
   assign w_push        = (r_state == ST_REQ) & w_ack & ~redirect_i;
   assign w_pop         = w_valid & ~stall_i & ~redirect_i;
   assign w_count_next  = redirect_i ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
   assign w_redirect_pc = redirect_pc_i & ~32'h0000_0003;
   assign w_fpc_next    = redirect_i ? w_redirect_pc :
                          (w_push ? (r_fpc + 32'd4) : r_fpc);
   // A new request is only issued when a slot will still be free after this
   // cycle's push/pop. That reserves room for the single outstanding fetch.
   assign w_can_issue   = start_i & (w_count_next < LP_DEPTH);

   // Fetch control FSM: it owns the fetch PC and the registered request outputs.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= ST_IDLE;
         r_fpc   <= RESET_PC;
         r_req   <= 1'b0;
         r_addr  <= RESET_PC;
      end else begin
         r_fpc <= w_fpc_next;
         case (r_state)
            ST_IDLE: begin
               r_addr <= w_fpc_next;
               if (w_can_issue) begin
                  r_state <= ST_REQ;
                  r_req   <= 1'b1;
               end else begin
                  r_req   <= 1'b0;
               end
            end
            ST_REQ: begin
               if (w_ack) begin
                  r_addr <= w_fpc_next;
                  if (w_can_issue) begin
                     r_state <= ST_REQ;
                     r_req   <= 1'b1;
                  end else begin
                     r_state <= ST_IDLE;
                     r_req   <= 1'b0;
                  end
               end else if (redirect_i) begin
                  // The bus request cannot be withdrawn. Keep it and drop its data.
                  r_state <= ST_DISCARD;
               end
            end
            ST_DISCARD: begin
               if (w_ack) begin
                  r_addr <= w_fpc_next;
                  if (w_can_issue) begin
                     r_state <= ST_REQ;
                     r_req   <= 1'b1;
                  end else begin
                     r_state <= ST_IDLE;
                     r_req   <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_req   <= 1'b0;
               r_addr  <= w_fpc_next;
            end
         endcase
      end
   end

   // Occupancy and pointers. A redirect empties the queue outright.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_count <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
      end else begin
         r_count <= w_count_next;
         if (redirect_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
         end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
         end
      end
   end

   // Entry storage. Contents are don't-care while the slot is unoccupied.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_fifo_pc[r_wptr]    <= r_addr;
         r_fifo_instr[r_wptr] <= imem.data;
      end
   end

   // A push into a full queue means a request went out without a reserved slot.
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i)
      !(w_push && (r_count == LP_DEPTH)));

   assign imem.req    = r_req;
   assign imem.addr   = r_addr;
   assign valid_o     = w_valid;
   assign pc_o        = w_valid ? r_fifo_pc[r_rptr]    : 32'd0;
   assign instr_o     = w_valid ? r_fifo_instr[r_rptr] : 32'd0;
   assign o_dbg_state = r_state;
   assign o_dbg_count = r_count;
endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed bench for if_fetch_buffer with a latency-programmable memory model,
// an expected-request queue checked on every ack, and an expected-output queue
// checked on every pop.
module tb_if_fetch_buffer;
   localparam logic [1:0]  ST_IDLE    = 2'd0;
   localparam logic [1:0]  ST_REQ     = 2'd1;
   localparam logic [1:0]  ST_DISCARD = 2'd2;
   localparam logic [31:0] RST_PC     = 32'h0000_0000;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        valid_o;
   logic [31:0] pc_o;
   logic [31:0] instr_o;
   logic [1:0]  dbg_state;
   logic [2:0]  dbg_count;

   if_fetch_buffer_if imem ();

   if_fetch_buffer #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .start_i       (start_i),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem          (imem),
      .valid_o       (valid_o),
      .pc_o          (pc_o),
      .instr_o       (instr_o),
      .o_dbg_state   (dbg_state),
      .o_dbg_count   (dbg_count)
   );

   // Clock and watchdog
   always #5 clk_i = ~clk_i;

   initial begin
      #100000;
      $fatal(1, "FAIL watchdog: observed no finish, expected finish before 100000");
   end

   int          n_total = 0;
   int          n_bad   = 0;
   int          mem_lat = 0;
   int          mem_wait = 0;
   logic [31:0] mem_hold;
   logic [31:0] salt;
   logic [31:0] mon_e;
   logic [31:0] req_exp_q[$];
   logic [31:0] exp_q[$];

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a ^ salt) + 32'h0001_0001;
   endfunction

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b0;
      step();
      step();
      rst_i = 1'b1;
   endtask

   task automatic push_seq(input logic [31:0] first, input int n, input bit to_out);
      for (int i = 0; i < n; i++) begin
         req_exp_q.push_back(first + 32'(4 * i));
         if (to_out) exp_q.push_back(first + 32'(4 * i));
      end
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while (!(exp_q.size() == 0 && req_exp_q.size() == 0 && !imem.req &&
               dbg_state == ST_IDLE) && n < 200) begin
         step();
         n++;
      end
      n_total++;
      assert (n < 200) else begin
         n_bad++;
         $error("FAIL %s: observed timeout after %0d cycles, expected drained", tag, n);
      end
      check32({tag, "_valid"}, 32'(valid_o), 32'd0);
   endtask

   // Memory model: acks after mem_lat wait cycles and checks every request.
   always @(negedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         imem.ack  = 1'b0;
         imem.data = 32'd0;
         mem_wait  = 0;
      end else begin
         imem.ack = 1'b0;
         if (imem.req) begin
            if (mem_wait == 0) mem_hold = imem.addr;
            else check32("req_addr_stable", imem.addr, mem_hold);
            if (mem_wait >= mem_lat) begin
               n_total++;
               assert (req_exp_q.size() != 0) else begin
                  n_bad++;
                  $error("FAIL req_unexpected: observed addr=%h, expected no request", imem.addr);
               end
               if (req_exp_q.size() != 0) check32("req_addr", imem.addr, req_exp_q.pop_front());
               imem.ack  = 1'b1;
               imem.data = instr_of(imem.addr);
               mem_wait  = 0;
            end else begin
               mem_wait++;
            end
         end
      end
   end

   // Output scoreboard: compare each consumed head entry with the queue.
   always @(negedge clk_i) begin
      if (rst_i) begin
         if (valid_o && !stall_i && !redirect_i) begin
            n_total++;
            assert (exp_q.size() != 0) else begin
               n_bad++;
               $error("FAIL pop_unexpected: observed pc=%h, expected no entry", pc_o);
            end
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check32("pop_pc", pc_o, mon_e);
               check32("pop_instr", instr_o, instr_of(mon_e));
            end
         end else if (!valid_o) begin
            check32("empty_pc", pc_o, 32'd0);
            check32("empty_instr", instr_o, 32'd0);
         end
      end
   end

   initial begin
      salt          = $urandom_range(32'h7FFF_FFFF, 0);
      rst_i         = 1'b0;
      start_i       = 1'b0;
      stall_i       = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'd0;
      step();
      step();
      check32("rst_req", 32'(imem.req), 32'd0);
      check32("rst_addr", imem.addr, RST_PC);
      check32("rst_valid", 32'(valid_o), 32'd0);
      check32("rst_pc", pc_o, 32'd0);
      check32("rst_instr", instr_o, 32'd0);
      check32("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      rst_i = 1'b1;

      // Streaming fetch, zero-wait memory, no stall
      push_seq(32'd0, 6, 1'b1);
      start_i = 1'b1;
      step();
      check32("s1_first_req", 32'(imem.req), 32'd1);
      check32("s1_first_addr", imem.addr, 32'd0);
      check32("s1_valid_lat", 32'(valid_o), 32'd0);
      step();
      check32("s1_valid_up", 32'(valid_o), 32'd1);
      check32("s1_head_pc", pc_o, 32'd0);
      check32("s1_next_addr", imem.addr, 32'd4);
      repeat (4) step();
      start_i = 1'b0;
      wait_drain("s1_drain");
      check32("s1_idle_addr", imem.addr, 32'd24);

      // Stall fills the buffer, then release resumes fetching at 16
      do_reset();
      stall_i = 1'b1;
      push_seq(32'd0, 7, 1'b1);
      start_i = 1'b1;
      repeat (5) step();
      check32("s2_full_req", 32'(imem.req), 32'd0);
      check32("s2_full_count", 32'(dbg_count), 32'd4);
      check32("s2_full_state", 32'(dbg_state), 32'(ST_IDLE));
      check32("s2_full_addr", imem.addr, 32'd16);
      check32("s2_head_pc", pc_o, 32'd0);
      repeat (3) begin
         step();
         check32("s2_hold_req", 32'(imem.req), 32'd0);
         check32("s2_hold_count", 32'(dbg_count), 32'd4);
      end
      stall_i = 1'b0;
      step();
      check32("s2_resume_req", 32'(imem.req), 32'd1);
      check32("s2_resume_addr", imem.addr, 32'd16);
      step();
      step();
      start_i = 1'b0;
      wait_drain("s2_drain");

      // Redirect while a slow request for 8 is outstanding
      do_reset();
      mem_lat = 3;
      stall_i = 1'b1;
      push_seq(32'd0, 3, 1'b0);
      push_seq(32'h100, 3, 1'b1);
      start_i = 1'b1;
      repeat (10) step();
      check32("s3_pre_count", 32'(dbg_count), 32'd2);
      check32("s3_pre_addr", imem.addr, 32'd8);
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h100;
      step();
      redirect_i = 1'b0;
      check32("s3_flush_valid", 32'(valid_o), 32'd0);
      check32("s3_flush_count", 32'(dbg_count), 32'd0);
      check32("s3_discard_state", 32'(dbg_state), 32'(ST_DISCARD));
      check32("s3_held_req", 32'(imem.req), 32'd1);
      check32("s3_held_addr", imem.addr, 32'd8);
      step();
      check32("s3_held_addr2", imem.addr, 32'd8);
      step();
      check32("s3_new_state", 32'(dbg_state), 32'(ST_REQ));
      check32("s3_new_addr", imem.addr, 32'h100);
      check32("s3_new_valid", 32'(valid_o), 32'd0);
      mem_lat = 0;
      stall_i = 1'b0;
      step();
      check32("s3_first_pc", pc_o, 32'h100);
      step();
      start_i = 1'b0;
      wait_drain("s3_drain");

      // Redirect in the same cycle as an ack, with two entries queued
      do_reset();
      stall_i = 1'b1;
      push_seq(32'd0, 3, 1'b0);
      push_seq(32'h200, 2, 1'b1);
      start_i = 1'b1;
      repeat (3) step();
      check32("s4_pre_count", 32'(dbg_count), 32'd2);
      check32("s4_pre_addr", imem.addr, 32'd8);
      stall_i       = 1'b0;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h200;
      step();
      redirect_i = 1'b0;
      check32("s4_valid", 32'(valid_o), 32'd0);
      check32("s4_count", 32'(dbg_count), 32'd0);
      check32("s4_req", 32'(imem.req), 32'd1);
      check32("s4_addr", imem.addr, 32'h200);
      step();
      check32("s4_first_pc", pc_o, 32'h200);
      start_i = 1'b0;
      wait_drain("s4_drain");

      // Unaligned redirect target near the top of the address space wraps
      req_exp_q.push_back(32'hFFFF_FFFC);
      exp_q.push_back(32'hFFFF_FFFC);
      push_seq(32'd0, 1, 1'b1);
      start_i       = 1'b1;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'hFFFF_FFFE;
      step();
      redirect_i = 1'b0;
      check32("s5_top_addr", imem.addr, 32'hFFFF_FFFC);
      check32("s5_top_state", 32'(dbg_state), 32'(ST_REQ));
      step();
      check32("s5_wrap_addr", imem.addr, 32'd0);
      start_i = 1'b0;
      wait_drain("s5_drain");
      check32("s5_idle_addr", imem.addr, 32'd4);

      // Asynchronous reset mid-request with three entries buffered
      stall_i = 1'b1;
      push_seq(32'd4, 3, 1'b0);
      start_i = 1'b1;
      repeat (4) step();
      check32("s6_pre_count", 32'(dbg_count), 32'd3);
      check32("s6_pre_addr", imem.addr, 32'd16);
      mem_lat = 5;
      step();
      check32("s6_pending_req", 32'(imem.req), 32'd1);
      check32("s6_pending_addr", imem.addr, 32'd16);
      #2;
      rst_i = 1'b0;
      #1;
      check32("s6_rst_req", 32'(imem.req), 32'd0);
      check32("s6_rst_addr", imem.addr, RST_PC);
      check32("s6_rst_valid", 32'(valid_o), 32'd0);
      check32("s6_rst_pc", pc_o, 32'd0);
      check32("s6_rst_instr", instr_o, 32'd0);
      check32("s6_rst_state", 32'(dbg_state), 32'(ST_IDLE));
      check32("s6_rst_count", 32'(dbg_count), 32'd0);
      step();
      mem_lat = 0;
      stall_i = 1'b0;
      push_seq(RST_PC, 1, 1'b1);
      rst_i = 1'b1;
      step();
      check32("s6_post_req", 32'(imem.req), 32'd1);
      check32("s6_post_addr", imem.addr, RST_PC);
      start_i = 1'b0;
      wait_drain("s6_drain");

      check32("end_req_q_left", 32'(req_exp_q.size()), 32'd0);
      check32("end_exp_q_left", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
